flags_register: RTL and testbench
=================================

# flags_register

Holds the four CPU status flags and feeds them straight into the control logic's `flags` input, where they select alternate microcode steps. Captures Z/N from the ALU result and C/V from the ALU carry/overflow under a per-flag update mask. Also restores flags from the data bus, drives them onto the bus, and provides set, clear and complement carry operations. Updates on the rising `clk` edge, so the control logic sees new flags on the following `iclk` evaluation.

## Interface
Parameters:
- `WIDTH`, 8, data bus and ALU result width (≥ 5)

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `alu_result`  in  WIDTH  ALU result for Z/N derivation
- `alu_carry`  in  1  ALU carry-out
- `alu_overflow`  in  1  ALU signed overflow
- `load_alu`  in  1  capture ALU flags selected by `mask`
- `mask`  in  4  per-flag update enable for `load_alu`; bit order as `flags`
- `data_in`  in  WIDTH  bus value; `data_in[3:0]` is loaded on `load_bus`
- `load_bus`  in  1  load all four flags from `data_in[3:0]`
- `out_en`  in  1  drive flags onto `data_out`
- `carry_set`  in  1  set C
- `carry_clr`  in  1  clear C; with `carry_set` high, complement C
- `shadow_save`  in  1  copy flags to shadow (only with `FLAGS_SHADOW_EN`)
- `shadow_restore`  in  1  load flags from shadow (only with `FLAGS_SHADOW_EN`)
- `flags`  out  4  {V, C, N, Z}: [3]=V, [2]=C, [1]=N, [0]=Z
- `data_out`  out  WIDTH  `{0…, flags}` when `out_en`, else all zero (no tristate)

## Operation
- Reset: `flags` = 4'h0, shadow = 4'h0, `data_out` = 0 (combinational from `out_en`). Reset is asynchronous and overrides every other input.
- Derived values:
  - Z = (`alu_result` == 0), N = `alu_result[WIDTH-1]`, C = `alu_carry`, V = `alu_overflow`.
  - `load_alu`: each flag bit i takes its derived value if `mask[i]`, else holds. `mask` = 0 is a no-op.
- Next-state priority, highest first; exactly one source writes `flags` per cycle:
  1. `load_bus`
  2. `shadow_restore`
  3. `load_alu`
  4. carry ops
- Carry ops apply only when none of sources 1–3 is active:
  - set only → C=1
  - clear only → C=0
  - both → C=~C
  - Z, N, V are held.
- Shadow:
  - `shadow_save` writes the pre-edge `flags` value into the shadow register, regardless of other loads in the same cycle.
  - `shadow_save` and `shadow_restore` together swap `flags` and shadow in one edge.
- `data_out` and `flags` are combinational from registered state and `out_en`. `data_out` never reflects same-cycle loads.
- `data_in[WIDTH-1:4]` is ignored.

## Timing
- Every load has 1-cycle latency: inputs sampled at rising `clk`, new `flags` visible immediately after that edge.
- A `load_bus` and an `out_en` in the same cycle are legal: `data_out` shows the old flags during that cycle.
- Reset asserted mid-operation clears `flags` and shadow asynchronously. The first load is accepted on the first rising edge after `rst` deasserts.
- No handshake; strobes are single-cycle. A strobe held N cycles re-applies N times (for example, complement toggles C every cycle).

## Configuration
- `FLAGS_SHADOW_EN` defined: shadow register, `shadow_save`, and `shadow_restore` are functional as above.
- Not defined: no shadow register is built; both ports remain in the port list but are ignored; priority reduces to `load_bus` > `load_alu` > carry ops.

## Test plan
- Reset, then release `rst` → `flags`=4'h0. `out_en`=1 → `data_out`=8'h00.
- `load_alu`, `mask`=4'hF, `alu_result`=8'h00, carry=1, overflow=0 → `flags`=4'h5. Then `alu_result`=8'h80, `mask`=4'h3 → `flags`=4'h6.
- `carry_set` → C=1 (`flags`=4'h4 from 0). Set+clr held 3 cycles → C sequence 0,1,0. Set+clr together with `load_alu` `mask`=4'h0 → flags unchanged.
- `load_bus`, `data_in`=8'hFA, with `load_alu` and `carry_clr` high in the same cycle → `flags`=4'hA. `out_en` in that cycle shows the previous value.
- `FLAGS_SHADOW_EN`: `flags`=4'h9; `shadow_save` → shadow=9. `load_bus` 8'h06 → 6. Save+restore → `flags`=9, shadow=6.
- Async `rst` pulse mid-cycle while `flags`=4'hF and a `load_alu` is pending → `flags`=0 immediately; no update at the next edge while `rst` is still high.

Source files
------------

// File: rtl/flags_register.sv
// CPU status flag register {V,C,N,Z} with ALU capture, bus load/drive and carry ops.
// Optional shadow copy with save/restore/swap when FLAGS_SHADOW_EN is defined.
module flags_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             load_alu,
    input  logic [3:0]       mask,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_bus,
    input  logic             out_en,
    input  logic             carry_set,
    input  logic             carry_clr,
    input  logic             shadow_save,
    input  logic             shadow_restore,
    output logic [3:0]       flags,
    output logic [WIDTH-1:0] data_out
);

    logic [3:0] flags_q, flags_d;
    logic [3:0] alu_flags;

    assign alu_flags = {alu_overflow, alu_carry, alu_result[WIDTH-1], (alu_result == '0)};

`ifdef FLAGS_SHADOW_EN
    logic [3:0] shadow_q, shadow_d;
    logic       unused_bus;

    assign unused_bus = ^data_in[WIDTH-1:4];

    always_comb begin
        flags_d = flags_q;
        if (load_bus)
            flags_d = data_in[3:0];
        else if (shadow_restore)
            flags_d = shadow_q;
        else if (load_alu)
            flags_d = (alu_flags & mask) | (flags_q & ~mask);
        else if (carry_set || carry_clr)
            flags_d[2] = (carry_set && carry_clr) ? ~flags_q[2] : carry_set;
    end

    // Save always captures the pre-edge flags, so save+restore swaps.
    assign shadow_d = shadow_save ? flags_q : shadow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q  <= 4'h0;
            shadow_q <= 4'h0;
        end else begin
            flags_q  <= flags_d;
            shadow_q <= shadow_d;
        end
    end
`else
    logic unused_inputs;

    assign unused_inputs = shadow_save ^ shadow_restore ^ (^data_in[WIDTH-1:4]);

    always_comb begin
        flags_d = flags_q;
        if (load_bus)
            flags_d = data_in[3:0];
        else if (load_alu)
            flags_d = (alu_flags & mask) | (flags_q & ~mask);
        else if (carry_set || carry_clr)
            flags_d[2] = (carry_set && carry_clr) ? ~flags_q[2] : carry_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flags_q <= 4'h0;
        else
            flags_q <= flags_d;
    end
`endif

    assign flags    = flags_q;
    assign data_out = out_en ? {{(WIDTH-4){1'b0}}, flags_q} : '0;

endmodule

// File: tb/tb_flags_register.sv
// Directed table-driven bench for flags_register plus reset and shadow sequences.
module tb_flags_register;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] alu_result;
    logic       alu_carry, alu_overflow, load_alu;
    logic [3:0] mask;
    logic [7:0] data_in;
    logic       load_bus, out_en, carry_set, carry_clr;
    logic       shadow_save, shadow_restore;
    logic [3:0] flags;
    logic [7:0] data_out;

    int total = 0;
    int bad   = 0;

    flags_register #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .alu_result(alu_result), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow), .load_alu(load_alu), .mask(mask),
        .data_in(data_in), .load_bus(load_bus), .out_en(out_en),
        .carry_set(carry_set), .carry_clr(carry_clr),
        .shadow_save(shadow_save), .shadow_restore(shadow_restore),
        .flags(flags), .data_out(data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       la;
        logic [3:0] mask;
        logic [7:0] res;
        logic       c;
        logic       v;
        logic       lb;
        logic [7:0] din;
        logic       cs;
        logic       cc;
        logic       oe;
        logic [7:0] exp_dout;
        logic [3:0] exp_flags;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        alu_result = 8'h00; alu_carry = 0; alu_overflow = 0; load_alu = 0; mask = 4'h0;
        data_in = 8'h00; load_bus = 0; out_en = 0; carry_set = 0; carry_clr = 0;
        shadow_save = 0; shadow_restore = 0;
    endtask

    initial begin
        //          la mask  res   c  v  lb din   cs cc oe dout  flags
        vecs[0]  = '{1, 4'hF, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1, 8'h00, 4'h5};
        vecs[1]  = '{1, 4'h3, 8'h80, 0, 0, 0, 8'h00, 0, 0, 1, 8'h05, 4'h6};
        vecs[2]  = '{0, 4'h0, 8'h00, 0, 0, 1, 8'hF0, 0, 0, 1, 8'h06, 4'h0};
        vecs[3]  = '{0, 4'h0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 4'h4};
        vecs[4]  = '{0, 4'h0, 8'h00, 0, 0, 0, 8'h00, 1, 1, 1, 8'h04, 4'h0};
        vecs[5]  = '{0, 4'h0, 8'h00, 0, 0, 0, 8'h00, 1, 1, 1, 8'h00, 4'h4};
        vecs[6]  = '{0, 4'h0, 8'h00, 0, 0, 0, 8'h00, 1, 1, 1, 8'h04, 4'h0};
        vecs[7]  = '{0, 4'h0, 8'h00, 0, 0, 1, 8'h07, 0, 0, 1, 8'h00, 4'h7};
        vecs[8]  = '{1, 4'h0, 8'h00, 1, 1, 0, 8'h00, 1, 1, 1, 8'h07, 4'h7};
        vecs[9]  = '{0, 4'h0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 1, 8'h07, 4'h3};
        vecs[10] = '{1, 4'hF, 8'h00, 1, 0, 1, 8'hFA, 0, 1, 1, 8'h03, 4'hA};
        vecs[11] = '{1, 4'h5, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1, 8'h0A, 4'hB};
        vecs[12] = '{1, 4'h2, 8'h7F, 1, 1, 0, 8'h00, 0, 0, 1, 8'h0B, 4'h9};
        vecs[13] = '{0, 4'h0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 8'h09, 4'h9};
        vecs[14] = '{0, 4'h0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 4'h9};

        clear_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        chk("reset_flags", {4'h0, flags}, 8'h00);
        rst = 0;
        out_en = 1;
        #1 chk("reset_dout", data_out, 8'h00);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            load_alu = vecs[i].la; mask = vecs[i].mask; alu_result = vecs[i].res;
            alu_carry = vecs[i].c; alu_overflow = vecs[i].v; load_bus = vecs[i].lb;
            data_in = vecs[i].din; carry_set = vecs[i].cs; carry_clr = vecs[i].cc;
            out_en = vecs[i].oe;
            #1 chk($sformatf("vec%0d_dout", i), data_out, vecs[i].exp_dout);
            @(posedge clk);
            #1 chk($sformatf("vec%0d_flags", i), {4'h0, flags}, {4'h0, vecs[i].exp_flags});
        end

        // Asynchronous reset while a load_alu is pending.
        @(negedge clk);
        clear_inputs();
        load_bus = 1; data_in = 8'h0F;
        @(posedge clk);
        #1 chk("pre_rst_flags", {4'h0, flags}, 8'h0F);
        @(negedge clk);
        load_bus = 0; load_alu = 1; mask = 4'hF; alu_result = 8'h00;
        #2 rst = 1;
        #1 chk("async_rst_flags", {4'h0, flags}, 8'h00);
        @(posedge clk);
        #1 chk("rst_held_flags", {4'h0, flags}, 8'h00);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1 chk("first_load_after_rst", {4'h0, flags}, 8'h01);

`ifdef FLAGS_SHADOW_EN
        @(negedge clk);
        clear_inputs();
        load_bus = 1; data_in = 8'h09;
        @(posedge clk);
        #1 chk("sh_load9", {4'h0, flags}, 8'h09);
        @(negedge clk);
        load_bus = 0; shadow_save = 1;
        @(posedge clk);
        #1 chk("sh_save", {4'h0, flags}, 8'h09);
        @(negedge clk);
        shadow_save = 0; load_bus = 1; data_in = 8'h06;
        @(posedge clk);
        #1 chk("sh_load6", {4'h0, flags}, 8'h06);
        @(negedge clk);
        load_bus = 0; shadow_save = 1; shadow_restore = 1;
        @(posedge clk);
        #1 chk("sh_swap", {4'h0, flags}, 8'h09);
        @(negedge clk);
        shadow_save = 0;
        @(posedge clk);
        #1 chk("sh_restore_swapped", {4'h0, flags}, 8'h06);
`else
        @(negedge clk);
        clear_inputs();
        shadow_save = 1; shadow_restore = 1;
        @(posedge clk);
        #1 chk("shadow_ignored", {4'h0, flags}, 8'h01);
        @(negedge clk);
        shadow_save = 0;
        @(posedge clk);
        #1 chk("restore_ignored", {4'h0, flags}, 8'h01);
`endif

        @(negedge clk);
        clear_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
